// File: rtl/sr_ff_arbiter.sv
// Four-requester arbiter sharing one external SR flip-flop: D, T, JK or hold commands are
// translated into s/r drive. Define SR_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module sr_ff_arbiter #(
  parameter int APPLY_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] mode,
  input  logic [3:0] din_a,
  input  logic [3:0] din_b,
  input  logic       q_fb,
  output logic       s,
  output logic       r,
  output logic [3:0] gnt,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, APPLY, ACK} state_t;

  localparam logic [3:0] LAST_CNT = 4'(APPLY_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] mode_q, mode_d;
  logic       a_q, a_d, b_q, b_d;
  logic       q_snap_q, q_snap_d;
  logic [3:0] cnt_q, cnt_d;
  logic       s_q, s_d, r_q, r_d;
  logic [3:0] gnt_q, gnt_d, ack_q, ack_d;
  logic       busy_q, busy_d;
  logic [1:0] start_s, cand_s, win_s, cmd_s;
  logic       found_s;

`ifdef SR_ARB_FIXED_PRIO_EN
  assign start_s = 2'd0;
`else
  logic [1:0] ptr_q, ptr_d;
  assign start_s = ptr_q;
`endif

  // Returns {s, r}; JK toggle reuses the T rule against the snapped q.
  function automatic logic [1:0] sr_cmd(input logic [1:0] m, input logic a,
                                        input logic b, input logic q);
    logic [1:0] res;
    case (m)
      2'b00:   res = {a, ~a};
      2'b01:   res = a ? {~q, q} : 2'b00;
      2'b10: begin
        case ({a, b})
          2'b10:   res = 2'b10;
          2'b01:   res = 2'b01;
          2'b11:   res = {~q, q};
          default: res = 2'b00;
        endcase
      end
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  // Winner search: first requesting index at or after start_s, wrapping mod 4.
  always_comb begin
    found_s = 1'b0;
    win_s   = start_s;
    cand_s  = start_s;
    for (int k = 0; k < 4; k++) begin
      cand_s = start_s + 2'(k);
      if (!found_s && req[cand_s]) begin
        win_s = cand_s;
      end else begin
        win_s = win_s;
      end
      found_s = found_s | req[cand_s];
    end
  end

  // Next state, operand latching and registered-output next values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    q_snap_d = q_snap_q;
    cnt_d    = cnt_q;
`ifndef SR_ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found_s) begin
          idx_d   = win_s;
          mode_d  = mode[2*win_s +: 2];
          a_d     = din_a[win_s];
          b_d     = din_b[win_s];
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        q_snap_d = q_fb;
        cnt_d    = 4'd0;
        state_d  = APPLY;
      end
      APPLY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 4'd0;
          state_d = ACK;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ACK: begin
`ifndef SR_ARB_FIXED_PRIO_EN
        ptr_d   = idx_q + 2'd1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Command is formed from the q value captured on the GRANT->APPLY edge.
    cmd_s  = sr_cmd(mode_q, a_q, b_q, q_snap_d);
    busy_d = (state_d != IDLE);
    if (state_d == APPLY) begin
      s_d = cmd_s[1];
      r_d = cmd_s[0];
    end else begin
      s_d = 1'b0;
      r_d = 1'b0;
    end
    if (state_d != IDLE) begin
      gnt_d = 4'b0001 << idx_d;
    end else begin
      gnt_d = 4'b0000;
    end
    if (state_d == ACK) begin
      ack_d = 4'b0001 << idx_d;
    end else begin
      ack_d = 4'b0000;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      mode_q   <= 2'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      q_snap_q <= 1'b0;
      cnt_q    <= 4'd0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      gnt_q    <= 4'd0;
      ack_q    <= 4'd0;
      busy_q   <= 1'b0;
`ifndef SR_ARB_FIXED_PRIO_EN
      ptr_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_snap_q <= q_snap_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      r_q      <= r_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
`ifndef SR_ARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign s    = s_q;
  assign r    = r_q;
  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sr_ff_arbiter.sv
// Scoreboard bench for sr_ff_arbiter: dut_a uses APPLY_CYCLES=1, dut_b uses APPLY_CYCLES=3.
module tb_sr_ff_arbiter;

  typedef struct {
    logic [3:0] g;
    int         sc;
    int         rc;
  } exp_t;

  logic clk;
  logic rst_a, rst_b, qfb_a, qfb_b;
  logic [3:0] req_a, req_b, da_a, da_b, db_a, db_b;
  logic [7:0] mode_a, mode_b;
  logic s_a, r_a, busy_a, s_b, r_b, busy_b;
  logic [3:0] gnt_a, ack_a, gnt_b, ack_b;
  logic rse_a, rse_b;

  int total = 0;
  int bad   = 0;
  exp_t exp_qa[$];
  exp_t exp_qb[$];
  logic [3:0] cap[2];
  int sc[2], rc[2];
  logic pack[2];
  int rr[5];

  sr_ff_arbiter #(.APPLY_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .mode(mode_a), .din_a(da_a), .din_b(db_a),
    .q_fb(qfb_a), .s(s_a), .r(r_a), .gnt(gnt_a), .ack(ack_a), .busy(busy_a));

  sr_ff_arbiter #(.APPLY_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .mode(mode_b), .din_a(da_b), .din_b(db_b),
    .q_fb(qfb_b), .s(s_b), .r(r_b), .gnt(gnt_b), .ack(ack_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rse_a <= rst_a;
    rse_b <= rst_b;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop on every ack pulse.
  task automatic mon(input int d, input logic [3:0] g, input logic [3:0] a,
                     input logic s, input logic r, input logic b, input logic rse);
    exp_t e;
    if (rse) begin
      chk("rst_outputs", 32'({g, a, s, r, b}), 32'd0);
      cap[d] = 4'd0; sc[d] = 0; rc[d] = 0; pack[d] = 1'b0;
    end else begin
      chk("sr_exclusive", 32'(s & r), 32'd0);
      chk("gnt_onehot0", 32'($onehot0(g)), 32'd1);
      chk("ack_onehot0", 32'($onehot0(a)), 32'd1);
      chk("busy_vs_gnt", 32'(b), 32'(g != 4'd0));
      if (pack[d]) chk("idle_after_ack", 32'(b), 32'd0);
      if (g != 4'd0) cap[d] = g;
      sc[d] += int'(s);
      rc[d] += int'(r);
      if (a != 4'd0) begin
        if ((d == 0 && exp_qa.size() == 0) || (d == 1 && exp_qb.size() == 0)) begin
          chk("unexpected_ack", 32'(a), 32'd0);
        end else begin
          if (d == 0) e = exp_qa.pop_front();
          else        e = exp_qb.pop_front();
          chk("ack_value", 32'(a), 32'(e.g));
          chk("gnt_held", 32'(cap[d]), 32'(e.g));
          chk("s_cycles", 32'(sc[d]), 32'(e.sc));
          chk("r_cycles", 32'(rc[d]), 32'(e.rc));
        end
        cap[d] = 4'd0; sc[d] = 0; rc[d] = 0;
      end
      pack[d] = (a != 4'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, gnt_a, ack_a, s_a, r_a, busy_a, rse_a);
    mon(1, gnt_b, ack_b, s_b, r_b, busy_b, rse_b);
  end

  task automatic push_exp(input int d, input logic [3:0] g, input int es, input int er);
    exp_t e;
    e.g = g;
    e.sc = es;
    e.rc = er;
    if (d == 0) exp_qa.push_back(e);
    else        exp_qb.push_back(e);
  endtask

  task automatic wait_idle(input int d);
    logic done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
      done = (d == 0) ? !busy_a : !busy_b;
    end
    if (!done) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // One request: operands scrambled and req dropped right after the latch edge.
  task automatic issue(input int d, input int id, input logic [1:0] m, input logic a,
                       input logic b, input logic q, input int es, input int er);
    logic [7:0] mv;
    logic [3:0] av, bv, rv;
    int ac;
    rv = 4'd0;  rv[id] = 1'b1;
    mv = 8'h00; mv[2*id +: 2] = m;
    av = {4{~a}}; av[id] = a;
    bv = {4{~b}}; bv[id] = b;
    ac = (d == 0) ? 1 : 3;
    if (d == 0) begin
      req_a = rv; mode_a = mv; da_a = av; db_a = bv; qfb_a = q;
    end else begin
      req_b = rv; mode_b = mv; da_b = av; db_b = bv; qfb_b = q;
    end
    push_exp(d, rv, es * ac, er * ac);
    @(negedge clk);
    if (d == 0) begin
      req_a = 4'd0; mode_a = ~mv; da_a = ~av; db_a = ~bv;
    end else begin
      req_b = 4'd0; mode_b = ~mv; da_b = ~av; db_b = ~bv;
    end
    wait_idle(d);
  endtask

  initial begin
    int nack;
`ifdef SR_ARB_FIXED_PRIO_EN
    rr[0] = 0; rr[1] = 0; rr[2] = 0; rr[3] = 0; rr[4] = 0;
`else
    rr[0] = 0; rr[1] = 1; rr[2] = 2; rr[3] = 3; rr[4] = 0;
`endif
    rst_a = 1'b1; rst_b = 1'b1; req_a = 4'd0; req_b = 4'd0;
    mode_a = 8'd0; mode_b = 8'd0; da_a = 4'd0; da_b = 4'd0;
    db_a = 4'd0; db_b = 4'd0; qfb_a = 1'b0; qfb_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Idle after reset: everything quiet.
    repeat (3) begin
      @(negedge clk);
      chk("idle_outputs", 32'({gnt_a, ack_a, s_a, r_a, busy_a}), 32'd0);
    end

    // Single D=1 request on requester 0: exact latency.
    req_a = 4'b0001; mode_a = 8'h00; da_a = 4'b0001;
    push_exp(0, 4'b0001, 1, 0);
    @(negedge clk);
    req_a = 4'd0;
    chk("lat_gnt", 32'(gnt_a), 32'h1);
    chk("lat_grant_sr", 32'({s_a, r_a}), 32'd0);
    @(negedge clk);
    chk("lat_apply_sr", 32'({s_a, r_a}), 32'b10);
    @(negedge clk);
    chk("lat_ack", 32'(ack_a), 32'h1);
    chk("lat_ack_sr", 32'({s_a, r_a}), 32'd0);
    @(negedge clk);
    chk("lat_idle", 32'(busy_a), 32'd0);

    // Command table on dut_a: d, id, mode, a(D/T/J), b(K), q_fb, expected s, r.
    issue(0, 1, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1);
    issue(0, 2, 2'b01, 1'b1, 1'b0, 1'b1, 0, 1);
    issue(0, 3, 2'b01, 1'b1, 1'b0, 1'b0, 1, 0);
    issue(0, 1, 2'b01, 1'b0, 1'b1, 1'b1, 0, 0);
    issue(0, 0, 2'b10, 1'b1, 1'b0, 1'b1, 1, 0);
    issue(0, 2, 2'b10, 1'b0, 1'b1, 1'b0, 0, 1);
    issue(0, 3, 2'b10, 1'b1, 1'b1, 1'b0, 1, 0);
    issue(0, 1, 2'b10, 1'b1, 1'b1, 1'b1, 0, 1);
    issue(0, 0, 2'b10, 1'b0, 1'b0, 1'b1, 0, 0);
    issue(0, 2, 2'b11, 1'b1, 1'b1, 1'b0, 0, 0);
    issue(0, 2, 2'b00, 1'b1, 1'b0, 1'b0, 1, 0);

    // All four held in hold mode from a fresh reset; arbitration in first rst=0 cycle.
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0; req_a = 4'b1111; mode_a = 8'hFF; da_a = 4'b1111; db_a = 4'b1111;
    for (int i = 0; i < 5; i++) push_exp(0, 4'b0001 << rr[i], 0, 0);
    @(negedge clk);
    chk("first_arb_gnt", 32'(gnt_a), 32'h1);
    nack = 0;
    for (int i = 0; i < 60 && nack < 5; i++) begin
      @(negedge clk);
      if (ack_a != 4'd0) nack++;
      if (nack == 5) req_a = 4'd0;
    end
    chk("rr_ack_count", 32'(nack), 32'd5);
    wait_idle(0);

    // dut_b: D=0 holds r for three cycles.
    issue(1, 0, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1);
    // dut_b: reset in the 2nd APPLY cycle aborts with no ack.
    req_b = 4'b0001; mode_b = 8'h00; da_b = 4'b0000;
    @(negedge clk);
    req_b = 4'd0;
    @(negedge clk);
    chk("abort_apply1_r", 32'({s_b, r_b}), 32'b01);
    @(negedge clk);
    chk("abort_apply2_r", 32'({s_b, r_b}), 32'b01);
    rst_b = 1'b1;
    @(negedge clk);
    chk("abort_outputs", 32'({gnt_b, ack_b, s_b, r_b, busy_b}), 32'd0);
    rst_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_stays_idle", 32'(busy_b), 32'd0);
    issue(1, 3, 2'b00, 1'b1, 1'b0, 1'b0, 1, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_a_empty", 32'(exp_qa.size()), 32'd0);
    chk("scoreboard_b_empty", 32'(exp_qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_ff_arbiter.md
SR_FF_ARBITER -- requirements
Module: sr_ff_arbiter

Interface
REQ-001 Parameter: APPLY_CYCLES, default 1, number of consecutive clk cycles s/r are held for one command (legal 1..15).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 Port: mode  input  8  per-requester command type, bits [2i+1:2i]: 00 D, 01 T, 10 JK, 11 hold.
REQ-006 Port: din_a  input  4  per-requester D / T / J operand.
REQ-007 Port: din_b  input  4  per-requester K operand; ignored unless mode is JK.
REQ-008 Port: q_fb  input  1  current q of the shared SR flip-flop.
REQ-009 Port: s  output  1  set drive to the shared SR flip-flop.
REQ-010 Port: r  output  1  reset drive to the shared SR flip-flop.
REQ-011 Port: gnt  output  4  one-hot grant, held from GRANT through ACK.
REQ-012 Port: ack  output  4  one-hot, one-cycle completion pulse to the granted requester.
REQ-013 Port: busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, GRANT, APPLY, ACK; exactly one state active.
REQ-015 IDLE: if any req bit is high, select a winner, latch its mode, din_a, din_b and index, and go to GRANT; otherwise stay in IDLE.
REQ-016 GRANT: assert gnt[winner], sample q_fb into q_snap, compute the s/r command, go to APPLY.
REQ-017 APPLY: drive the computed s/r for APPLY_CYCLES cycles using a 4-bit counter, then go to ACK.
REQ-018 ACK: s=r=0, ack[winner]=1 for exactly this cycle, go to IDLE.
REQ-019 Latency: req rising in IDLE gives gnt on cycle +1, s/r on cycles +2..+1+APPLY_CYCLES, and ack on cycle +2+APPLY_CYCLES.
REQ-020 D mode: s=d, r=~d.
REQ-021 T mode: if t=1 then s=~q_snap, r=q_snap; if t=0 then s=r=0.
REQ-022 JK mode:
- J=1,K=0: s=1, r=0
- J=0,K=1: s=0, r=1
- J=1,K=1: toggle, using the T rule on q_snap
- J=0,K=0: s=r=0
REQ-023 Hold mode (11): s=r=0 for the full APPLY window; ack is still issued.
REQ-024 s and r are never high in the same cycle; s=r=0 in every state other than APPLY.
REQ-025 Operands are latched in IDLE; changes to req, mode, din_a or din_b after the latch do not affect the operation in flight.
REQ-026 A requester that drops req before its ack still has its operation completed and acked.
REQ-027 Round-robin arbitration: the search starts at ptr, the lowest-numbered requester at or after ptr (mod 4) wins, and ptr becomes winner+1 (mod 4, wraps 3->0) in the ACK cycle.
REQ-028 A req bit that stays high is re-arbitrated in the IDLE cycle that follows ACK; there is no back-to-back grant without that IDLE cycle.
REQ-029 At most one gnt bit and at most one ack bit are high in any cycle.

Reset
REQ-030 When rst=1 at a clk edge: state=IDLE, ptr=0, counter=0, q_snap=0, s=0, r=0, gnt=0, ack=0, busy=0.
REQ-031 rst has priority over all other inputs; reset mid-operation aborts it with no ack, and the aborted requester must re-request.
REQ-032 The first arbitration after reset can occur in the first cycle with rst=0.

Configuration
REQ-033 Macro SR_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (requester 0 highest, 3 lowest) and ptr is not implemented; when undefined, the round-robin of REQ-027 applies.

Verification
REQ-034 rst=1 for 2 cycles, then req=0000 -> all outputs 0 and busy=0 on every cycle.
REQ-035 req=0001, mode D, din_a[0]=1, APPLY_CYCLES=1 -> gnt=0001 at +1, s=1 r=0 at +2, ack=0001 at +3, then IDLE.
REQ-036 req=1111 held, all in hold mode -> grant order 0,1,2,3,0 (round robin); with SR_ARB_FIXED_PRIO_EN defined, requester 0 is granted every time.
REQ-037 T mode t=1 with q_fb=1 -> s=0 r=1; JK J=K=1 with q_fb=0 -> s=1 r=0; JK J=K=0 -> s=r=0; s&r never 1 in any cycle.
REQ-038 APPLY_CYCLES=3, D mode d=0 -> r=1 for exactly 3 cycles; rst=1 asserted in the 2nd APPLY cycle -> next cycle all outputs 0, no ack.
REQ-039 Requester 2 drops req during GRANT -> its operation still completes and ack=0100 is pulsed.
